// File: rtl/alu_seq_if.sv
// Request, result and ALU-control bundle between a requester, alu_seq and the external ALU.
// The slave side is the sequencer. The master side is the requester, consumer and ALU.
interface alu_seq_if;
  logic       REQ_VLD;
  logic       REQ_RDY;
  logic [2:0] REQ_OP;
  logic [7:0] REQ_A;
  logic [7:0] REQ_B;
  logic [7:0] Din;
  logic       An;
  logic       Bn;
  logic       ISUMn;
  logic       ISUBn;
  logic       IMULn;
  logic       IDIVn;
  logic       ISHLn;
  logic       ISHRn;
  logic [7:0] ALU_RES;
  logic       RES_VLD;
  logic       RES_RDY;
  logic [7:0] RES;
  logic       ERR;
  logic [7:0] OPCNT;

  modport slave (
    input  REQ_VLD, REQ_OP, REQ_A, REQ_B, ALU_RES, RES_RDY,
    output REQ_RDY, Din, An, Bn, ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn,
           RES_VLD, RES, ERR, OPCNT
  );

  modport master (
    output REQ_VLD, REQ_OP, REQ_A, REQ_B, ALU_RES, RES_RDY,
    input  REQ_RDY, Din, An, Bn, ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn,
           RES_VLD, RES, ERR, OPCNT
  );
endinterface

// File: rtl/alu_seq.sv
// Sequences an external ALU: load A, load B, execute, capture, then hold the result for the consumer.
// Every output is registered. Output values are derived from the next state.
//   state | meaning
//   IDLE  | ready for a request
//   LDA   | Din = A, An low
//   LDB   | Din = B, Bn low
//   EXEC  | op select low
//   CAPT  | op select low, ALU_RES captured on exit
//   DONE  | result valid, waiting for RES_RDY
module alu_seq (
  input logic      CLK,
  input logic      RSTn,
  alu_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LDA, LDB, EXEC, CAPT, DONE} state_t;
  localparam logic [2:0] OP_DIV = 3'd3;

  state_t     state, state_nx;
  logic [2:0] op_q;
  logic [7:0] b_q;
  logic       rdy_q, vld_q, err_q, an_q, bn_q;
  logic [7:0] res_q, din_q, cnt_q;
  logic [5:0] sel_q;
  logic       rdy_nx, vld_nx, err_nx, an_nx, bn_nx;
  logic [7:0] res_nx, din_nx, cnt_nx;
  logic [5:0] sel_nx;
  logic       accept, bad_op, div_zero;

  assign accept   = (state == IDLE) && bus.REQ_VLD;
  assign bad_op   = bus.REQ_OP[2] & bus.REQ_OP[1];
  assign div_zero = (bus.REQ_OP == OP_DIV) && (bus.REQ_B == 8'h00);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      op_q  <= 3'd0;
      b_q   <= 8'h00;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      res_q <= 8'h00;
      cnt_q <= 8'h00;
      din_q <= 8'h00;
      an_q  <= 1'b1;
      bn_q  <= 1'b1;
      sel_q <= '1;
    end else begin
      state <= state_nx;
      rdy_q <= rdy_nx;
      vld_q <= vld_nx;
      err_q <= err_nx;
      res_q <= res_nx;
      cnt_q <= cnt_nx;
      din_q <= din_nx;
      an_q  <= an_nx;
      bn_q  <= bn_nx;
      sel_q <= sel_nx;
      if (accept) begin
        op_q <= bus.REQ_OP;
        b_q  <= bus.REQ_B;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.REQ_VLD) state_nx = (bad_op || div_zero) ? DONE : LDA;
      LDA:  state_nx = LDB;
      LDB:  state_nx = EXEC;
      EXEC: state_nx = CAPT;
      CAPT: state_nx = DONE;
      DONE: if (bus.RES_RDY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdy_nx = (state_nx == IDLE);
    vld_nx = (state_nx == DONE);
    an_nx  = 1'b1;
    bn_nx  = 1'b1;
    sel_nx = '1;
    din_nx = 8'h00;
    res_nx = res_q;
    err_nx = err_q;
    cnt_nx = cnt_q;
    case (state_nx)
      // LDA is entered only from IDLE, so A comes straight off the request bus
      LDA: begin
        an_nx  = 1'b0;
        din_nx = bus.REQ_A;
      end
      LDB: begin
        bn_nx  = 1'b0;
        din_nx = b_q;
      end
      EXEC, CAPT: sel_nx = ~(6'b000001 << op_q);
      default: ;
    endcase
    if (accept && bad_op) begin
      res_nx = 8'h00;
      err_nx = 1'b1;
    end else if (accept && div_zero) begin
      res_nx = 8'hFF;
      err_nx = 1'b1;
    end else if (state == CAPT) begin
      res_nx = bus.ALU_RES;
      err_nx = 1'b0;
    end
    if (state == DONE && bus.RES_RDY) cnt_nx = cnt_q + 8'd1;
  end

  assign bus.REQ_RDY = rdy_q;
  assign bus.RES_VLD = vld_q;
  assign bus.RES     = res_q;
  assign bus.ERR     = err_q;
  assign bus.OPCNT   = cnt_q;
  assign bus.Din     = din_q;
  assign bus.An      = an_q;
  assign bus.Bn      = bn_q;
  assign bus.ISUMn   = sel_q[0];
  assign bus.ISUBn   = sel_q[1];
  assign bus.IMULn   = sel_q[2];
  assign bus.IDIVn   = sel_q[3];
  assign bus.ISHLn   = sel_q[4];
  assign bus.ISHRn   = sel_q[5];
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed requests with hand-computed results, a queue-based result scoreboard,
// and a behavioural ALU that loads on the strobes.
module tb_alu_seq;
  logic CLK;
  logic RSTn;
  int   vectors;
  int   miscompares;
  int   cyc;
  logic [7:0] exp_cnt;
  logic [8:0] sb_q[$];

  alu_seq_if bus ();

  alu_seq dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  // External ALU: operand registers load on the rising edge while their strobe is low.
  logic [7:0]  alu_a, alu_b, alu_res;
  logic [15:0] alu_prod;
  always @(posedge CLK) begin
    if (!bus.An) alu_a <= bus.Din;
    if (!bus.Bn) alu_b <= bus.Din;
  end
  always_comb begin
    alu_prod = {8'h00, alu_a} * {8'h00, alu_b};
    alu_res  = 8'h00;
    if (!bus.ISUMn)      alu_res = alu_a + alu_b;
    else if (!bus.ISUBn) alu_res = alu_a - alu_b;
    else if (!bus.IMULn) alu_res = alu_prod[7:0];
    else if (!bus.IDIVn) alu_res = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
    else if (!bus.ISHLn) alu_res = alu_a << 1;
    else if (!bus.ISHRn) alu_res = alu_a >> 1;
  end
  assign bus.ALU_RES = alu_res;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one expected {ERR,RES} per accepted request, popped at each result handshake.
  always @(negedge CLK) begin
    logic [8:0] e;
    if (RSTn && bus.RES_VLD && bus.RES_RDY) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got result %0h with no expected entry", bus.RES);
      end else begin
        e = sb_q.pop_front();
        chk("res", {8'h00, bus.RES}, {8'h00, e[7:0]});
        chk("err", {15'h0, bus.ERR}, {15'h0, e[8]});
        chk("opcnt_at_handshake", {8'h00, bus.OPCNT}, {8'h00, exp_cnt});
        exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  function automatic logic [5:0] sels();
    return {bus.ISHRn, bus.ISHLn, bus.IDIVn, bus.IMULn, bus.ISUBn, bus.ISUMn};
  endfunction

  // Entered and left at posedge+1 with the DUT in IDLE.
  // elat counts edges from the accepting edge up to and including the one entering DONE.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eres, input logic eerr, input int hold, input int elat);
    int lat, na, nb, nsel, nbad, guard;
    logic [5:0] want;
    want = ~(6'b000001 << op);
    na = 0; nb = 0; nsel = 0; nbad = 0; guard = 0; lat = 1;
    sb_q.push_back({eerr, eres});
    bus.RES_RDY = (hold == 0);
    bus.REQ_VLD = 1'b1;
    bus.REQ_OP  = op;
    bus.REQ_A   = a;
    bus.REQ_B   = b;
    @(negedge CLK);
    chk("req_rdy_idle", {15'h0, bus.REQ_RDY}, 16'h1);
    @(posedge CLK); #1;
    bus.REQ_VLD = 1'b0;
    bus.REQ_OP  = ~op;
    bus.REQ_A   = ~a;
    bus.REQ_B   = ~b;
    forever begin
      @(negedge CLK);
      if (bus.RES_VLD || guard > 20) break;
      if (!bus.An) begin
        na++;
        if (bus.Din !== a || sels() !== 6'h3F || !bus.Bn) nbad++;
      end else if (!bus.Bn) begin
        nb++;
        if (bus.Din !== b || sels() !== 6'h3F) nbad++;
      end else begin
        if (sels() === want) nsel++;
        else nbad++;
        if (bus.Din !== 8'h00) nbad++;
      end
      @(posedge CLK); #1;
      lat++;
      guard++;
    end
    chk("latency", lat[15:0], elat[15:0]);
    if (eerr) begin
      chk("err_no_strobes", (na + nb + nsel + nbad), 16'h0);
    end else begin
      chk("a_load_cycles", na[15:0], 16'h1);
      chk("b_load_cycles", nb[15:0], 16'h1);
      chk("select_cycles", nsel[15:0], 16'h2);
      chk("bad_strobe_cycles", nbad[15:0], 16'h0);
    end
    chk("req_rdy_in_done", {15'h0, bus.REQ_RDY}, 16'h0);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("hold_vld", {15'h0, bus.RES_VLD}, 16'h1);
        chk("hold_res", {8'h00, bus.RES}, {8'h00, eres});
        chk("hold_rdy", {15'h0, bus.REQ_RDY}, 16'h0);
        chk("hold_opcnt", {8'h00, bus.OPCNT}, {8'h00, exp_cnt});
      end
      @(posedge CLK); #1;
      bus.RES_RDY = 1'b1;
    end
    @(posedge CLK); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_rdy", {15'h0, bus.REQ_RDY}, 16'h1);
    chk("rst_res_vld", {15'h0, bus.RES_VLD}, 16'h0);
    chk("rst_res",     {8'h00, bus.RES}, 16'h0);
    chk("rst_err",     {15'h0, bus.ERR}, 16'h0);
    chk("rst_opcnt",   {8'h00, bus.OPCNT}, 16'h0);
    chk("rst_din",     {8'h00, bus.Din}, 16'h0);
    chk("rst_strobes", {8'h00, bus.An, bus.Bn, sels()}, 16'h00FF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vectors = 0; miscompares = 0; cyc = 0; exp_cnt = 8'h00;
    bus.REQ_VLD = 1'b0; bus.REQ_OP = 3'd0; bus.REQ_A = 8'h00; bus.REQ_B = 8'h00;
    bus.RES_RDY = 1'b0;
    RSTn = 1'b1;
    #2 RSTn = 1'b0;
    #2 chk_reset_outputs();
    @(posedge CLK); #1;
    RSTn = 1'b1;

    run_op(3'b000, 8'h07, 8'h06, 8'h0D, 1'b0, 0, 5);  // SUM
    chk("opcnt_after_sum", {8'h00, bus.OPCNT}, 16'h1);
    run_op(3'b011, 8'h09, 8'h00, 8'hFF, 1'b1, 0, 1);  // DIV by zero
    chk("opcnt_after_div0", {8'h00, bus.OPCNT}, 16'h2);
    run_op(3'b111, 8'h12, 8'h34, 8'h00, 1'b1, 0, 1);  // illegal
    run_op(3'b001, 8'h08, 8'h05, 8'h03, 1'b0, 4, 5);  // SUB with stalled consumer
    chk("opcnt_after_sub", {8'h00, bus.OPCNT}, 16'h4);
    run_op(3'b010, 8'h05, 8'h03, 8'h0F, 1'b0, 0, 5);  // MUL
    run_op(3'b011, 8'h64, 8'h07, 8'h0E, 1'b0, 0, 5);  // DIV 100/7
    run_op(3'b100, 8'h81, 8'h55, 8'h02, 1'b0, 0, 5);  // SHL, B ignored
    run_op(3'b101, 8'h81, 8'h55, 8'h40, 1'b0, 0, 5);  // SHR
    run_op(3'b110, 8'hAA, 8'h01, 8'h00, 1'b1, 2, 1);  // illegal, stalled

    // MUL abandoned by reset during EXEC
    bus.RES_RDY = 1'b1;
    bus.REQ_VLD = 1'b1; bus.REQ_OP = 3'b010; bus.REQ_A = 8'h10; bus.REQ_B = 8'h02;
    @(posedge CLK); #1;
    bus.REQ_VLD = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("mul_exec_select", {10'h0, sels()}, 16'h003B);
    #1 RSTn = 1'b0;
    #1 chk_reset_outputs();
    exp_cnt = 8'h00;
    @(posedge CLK); #1;
    RSTn = 1'b1;

    c0 = cyc;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] av, ev;
      av = i[7:0];
      ev = {av[6:0], 1'b0};
      run_op(3'b100, av, 8'h03, ev, 1'b0, 0, 5);
    end
    chk("shl_loop_cycles", (cyc - c0), 16'd1536);
    chk("opcnt_wrap", {8'h00, bus.OPCNT}, 16'h0);

    run_op(3'b010, 8'h0C, 8'h0B, 8'h84, 1'b0, 0, 5);  // MUL after reset
    chk("opcnt_final", {8'h00, bus.OPCNT}, 16'h1);
    chk("scoreboard_empty", sb_q.size(), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
